// File: rtl/xadac_pkg.sv
// xadac_pkg: shared types for the xadac request/response channels.
// SbLen sets the ID space (IDs 0..SbLen-1); every payload carries an ID.
package xadac_pkg;

  localparam int unsigned SbLen = 8;
  localparam int unsigned IdW   = $clog2(SbLen);

  typedef logic [IdW-1:0] id_t;

  typedef struct packed {
    id_t         id;
    logic [15:0] instr;
  } dec_req_t;

  typedef struct packed {
    id_t         id;
    logic [15:0] data;
  } dec_rsp_t;

  typedef struct packed {
    id_t         id;
    logic [15:0] data;
  } exe_req_t;

  typedef struct packed {
    id_t         id;
    logic [15:0] data;
  } exe_rsp_t;

endpackage

// File: rtl/xadac_if.sv
// xadac_if: decode/execute request and response channels, valid/ready handshaked.
// Modports:
//   mst - requester side (drives requests, accepts responses)
//   slv - accelerator side (accepts requests, drives responses)
interface xadac_if;
  import xadac_pkg::*;

  dec_req_t dec_req;
  logic     dec_req_valid;
  logic     dec_req_ready;
  dec_rsp_t dec_rsp;
  logic     dec_rsp_valid;
  logic     dec_rsp_ready;
  exe_req_t exe_req;
  logic     exe_req_valid;
  logic     exe_req_ready;
  exe_rsp_t exe_rsp;
  logic     exe_rsp_valid;
  logic     exe_rsp_ready;

  modport mst (
    output dec_req, dec_req_valid, input  dec_req_ready,
    input  dec_rsp, dec_rsp_valid, output dec_rsp_ready,
    output exe_req, exe_req_valid, input  exe_req_ready,
    input  exe_rsp, exe_rsp_valid, output exe_rsp_ready
  );

  modport slv (
    input  dec_req, dec_req_valid, output dec_req_ready,
    output dec_rsp, dec_rsp_valid, input  dec_rsp_ready,
    input  exe_req, exe_req_valid, output exe_req_ready,
    output exe_rsp, exe_rsp_valid, input  exe_rsp_ready
  );
endinterface

// File: rtl/xadac_arb.sv
// xadac_arb: merges NoSlv xadac requesters onto one accelerator port.
// Decode and execute requests are arbitrated round-robin with independent pointers; a grant
// is held while the accelerator stalls it. A scoreboard indexed by ID remembers which
// requester issued each decode request so responses are routed back by ID.
// Ports:
//   clk  - clock, rising edge
//   rstn - asynchronous active-low reset
//   slv  - requester-facing ports [NoSlv]
//   mst  - accelerator-facing port
// Optional: define XADAC_ARB_ID_CHECK_EN to hold off decode requests whose ID is still
// outstanding and to accept-and-drop responses for IDs that are not outstanding.
module xadac_arb import xadac_pkg::*; #(
  parameter int unsigned NoSlv = 2
) (
  input logic   clk,
  input logic   rstn,
  xadac_if.slv  slv [NoSlv],
  xadac_if.mst  mst
);

  localparam int unsigned SbLen = xadac_pkg::SbLen;
  localparam int unsigned SrcW  = (NoSlv > 1) ? $clog2(NoSlv) : 1;
  typedef logic [SrcW-1:0] src_t;

  logic [NoSlv-1:0] dec_req_v, exe_req_v, dec_req_rdy, exe_req_rdy;
  logic [NoSlv-1:0] dec_rsp_v, exe_rsp_v, dec_rsp_rdy, exe_rsp_rdy;
  dec_req_t         dec_req_pl [NoSlv];
  exe_req_t         exe_req_pl [NoSlv];
  dec_rsp_t         dec_rsp_pl [NoSlv];
  exe_rsp_t         exe_rsp_pl [NoSlv];

  for (genvar g = 0; g < NoSlv; g++) begin : g_port
    assign dec_req_v[g]          = slv[g].dec_req_valid;
    assign dec_req_pl[g]         = slv[g].dec_req;
    assign slv[g].dec_req_ready  = dec_req_rdy[g];
    assign exe_req_v[g]          = slv[g].exe_req_valid;
    assign exe_req_pl[g]         = slv[g].exe_req;
    assign slv[g].exe_req_ready  = exe_req_rdy[g];
    assign slv[g].dec_rsp        = dec_rsp_pl[g];
    assign slv[g].dec_rsp_valid  = dec_rsp_v[g];
    assign dec_rsp_rdy[g]        = slv[g].dec_rsp_ready;
    assign slv[g].exe_rsp        = exe_rsp_pl[g];
    assign slv[g].exe_rsp_valid  = exe_rsp_v[g];
    assign exe_rsp_rdy[g]        = slv[g].exe_rsp_ready;
  end

  src_t             dec_ptr_q, exe_ptr_q, dec_gnt_q, exe_gnt_q;
  logic             dec_lock_q, exe_lock_q;
  logic [SbLen-1:0] sb_vld_q;
  src_t             sb_src_q [SbLen];

  // First requester at or after ptr, wrapping; returns ptr when nobody requests.
  function automatic src_t rr_pick(input logic [NoSlv-1:0] req, input src_t ptr);
    src_t pick;
    logic found;
    int   j;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < int'(NoSlv); i++) begin
      j = int'(ptr) + i;
      if (j >= int'(NoSlv)) j = j - int'(NoSlv);
      if (!found && req[j]) begin
        pick  = src_t'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic src_t rr_next(input src_t g);
    return (g == src_t'(NoSlv - 1)) ? '0 : g + src_t'(1);
  endfunction

  // Request arbitration
  logic [NoSlv-1:0] dec_req_eff;
  src_t             dec_gnt, exe_gnt;
  logic             dec_mv, exe_mv, dec_hs, exe_hs;

  always_comb begin
    dec_req_eff = dec_req_v;
`ifdef XADAC_ARB_ID_CHECK_EN
    for (int i = 0; i < int'(NoSlv); i++) begin
      if (sb_vld_q[dec_req_pl[i].id]) dec_req_eff[i] = 1'b0;
    end
`endif
    dec_gnt = dec_lock_q ? dec_gnt_q : rr_pick(dec_req_eff, dec_ptr_q);
    exe_gnt = exe_lock_q ? exe_gnt_q : rr_pick(exe_req_v, exe_ptr_q);
    dec_mv  = rstn & dec_req_eff[dec_gnt];
    exe_mv  = rstn & exe_req_v[exe_gnt];
    dec_req_rdy          = '0;
    exe_req_rdy          = '0;
`ifdef XADAC_ARB_ID_CHECK_EN
    // A held-off port may sit at the pointer; it must never see ready.
    dec_req_rdy[dec_gnt] = rstn & mst.dec_req_ready & dec_req_eff[dec_gnt];
`else
    dec_req_rdy[dec_gnt] = rstn & mst.dec_req_ready;
`endif
    exe_req_rdy[exe_gnt] = rstn & mst.exe_req_ready;
    dec_hs = dec_mv & mst.dec_req_ready;
    exe_hs = exe_mv & mst.exe_req_ready;
  end

  assign mst.dec_req       = dec_req_pl[dec_gnt];
  assign mst.dec_req_valid = dec_mv;
  assign mst.exe_req       = exe_req_pl[exe_gnt];
  assign mst.exe_req_valid = exe_mv;

  // Response routing by scoreboard lookup; purely combinational
  src_t dec_rsp_src, exe_rsp_src;
  logic dec_rsp_hit, exe_rsp_hit, dec_rsp_mrdy, exe_rsp_mrdy, exe_rsp_hs;

  always_comb begin
    dec_rsp_src = sb_src_q[mst.dec_rsp.id];
    exe_rsp_src = sb_src_q[mst.exe_rsp.id];
`ifdef XADAC_ARB_ID_CHECK_EN
    dec_rsp_hit = sb_vld_q[mst.dec_rsp.id];
    exe_rsp_hit = sb_vld_q[mst.exe_rsp.id];
`else
    dec_rsp_hit = 1'b1;
    exe_rsp_hit = 1'b1;
`endif
    for (int i = 0; i < int'(NoSlv); i++) begin
      dec_rsp_v[i]  = rstn & mst.dec_rsp_valid & dec_rsp_hit & (dec_rsp_src == src_t'(i));
      exe_rsp_v[i]  = rstn & mst.exe_rsp_valid & exe_rsp_hit & (exe_rsp_src == src_t'(i));
      dec_rsp_pl[i] = (dec_rsp_src == src_t'(i)) ? mst.dec_rsp : '0;
      exe_rsp_pl[i] = (exe_rsp_src == src_t'(i)) ? mst.exe_rsp : '0;
    end
    // Unknown IDs (check build only) are swallowed so the accelerator never stalls on them.
    dec_rsp_mrdy = rstn & (dec_rsp_hit ? dec_rsp_rdy[dec_rsp_src] : 1'b1);
    exe_rsp_mrdy = rstn & (exe_rsp_hit ? exe_rsp_rdy[exe_rsp_src] : 1'b1);
    exe_rsp_hs   = mst.exe_rsp_valid & exe_rsp_mrdy;
  end

  assign mst.dec_rsp_ready = dec_rsp_mrdy;
  assign mst.exe_rsp_ready = exe_rsp_mrdy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dec_ptr_q  <= '0;
      exe_ptr_q  <= '0;
      dec_gnt_q  <= '0;
      exe_gnt_q  <= '0;
      dec_lock_q <= 1'b0;
      exe_lock_q <= 1'b0;
      sb_vld_q   <= '0;
      for (int i = 0; i < int'(SbLen); i++) sb_src_q[i] <= '0;
    end else begin
      dec_lock_q <= dec_mv & ~mst.dec_req_ready;
      exe_lock_q <= exe_mv & ~mst.exe_req_ready;
      dec_gnt_q  <= dec_gnt;
      exe_gnt_q  <= exe_gnt;
      if (dec_hs) dec_ptr_q <= rr_next(dec_gnt);
      if (exe_hs) exe_ptr_q <= rr_next(exe_gnt);
      if (exe_rsp_hs) sb_vld_q[mst.exe_rsp.id] <= 1'b0;
      // Placed after the free so a same-cycle allocation of that ID wins.
      if (dec_hs) begin
        sb_vld_q[mst.dec_req.id] <= 1'b1;
        sb_src_q[mst.dec_req.id] <= dec_gnt;
      end
    end
  end

endmodule

// File: tb/tb_xadac_arb.sv
module tb_xadac_arb;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  xadac_if s_if [2] ();
  xadac_if m_if ();

  xadac_arb #(.NoSlv(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .slv  (s_if),
    .mst  (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    s_if[0].dec_req = '0; s_if[0].dec_req_valid = 1'b0; s_if[0].dec_rsp_ready = 1'b0;
    s_if[0].exe_req = '0; s_if[0].exe_req_valid = 1'b0; s_if[0].exe_rsp_ready = 1'b0;
    s_if[1].dec_req = '0; s_if[1].dec_req_valid = 1'b0; s_if[1].dec_rsp_ready = 1'b0;
    s_if[1].exe_req = '0; s_if[1].exe_req_valid = 1'b0; s_if[1].exe_rsp_ready = 1'b0;
    m_if.dec_req_ready = 1'b0; m_if.dec_rsp = '0; m_if.dec_rsp_valid = 1'b0;
    m_if.exe_req_ready = 1'b0; m_if.exe_rsp = '0; m_if.exe_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    s_if[0].dec_req_valid = 1'b1;
    m_if.dec_req_ready = 1'b1;
    @(negedge clk);
    total++;
    if (m_if.dec_req_valid !== 1'b0) begin
      bad++; $display("FAIL reset_mst_valid got=%b want=0", m_if.dec_req_valid);
    end
    total++;
    if (s_if[0].dec_req_ready !== 1'b0) begin
      bad++; $display("FAIL reset_slv_ready got=%b want=0", s_if[0].dec_req_ready);
    end
    idle();
    #1 rstn = 1'b1;
    @(negedge clk);
    total++;
    if (dut.dec_ptr_q !== 1'b0 || dut.exe_ptr_q !== 1'b0 || dut.sb_vld_q !== 8'h00) begin
      bad++;
      $display("FAIL reset_state got ptr=%b/%b vld=%h want 0/0/00", dut.dec_ptr_q,
               dut.exe_ptr_q, dut.sb_vld_q);
    end
  endtask

  task automatic test_dec_rr();
    do_reset();
    s_if[0].dec_req.id = 3'd1; s_if[0].dec_req_valid = 1'b1;
    s_if[1].dec_req.id = 3'd2; s_if[1].dec_req_valid = 1'b1;
    m_if.dec_req_ready = 1'b1;
    @(negedge clk);
    total++;
    if (m_if.dec_req.id !== 3'd1 || s_if[0].dec_req_ready !== 1'b1 ||
        s_if[1].dec_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL rr_cycle0 got id=%0d rdy=%b%b want id=1 rdy=01", m_if.dec_req.id,
               s_if[1].dec_req_ready, s_if[0].dec_req_ready);
    end
    step();
    // slv0 keeps requesting with a new ID; pointer now favours slv1.
    s_if[0].dec_req.id = 3'd4;
    @(negedge clk);
    total++;
    if (m_if.dec_req.id !== 3'd2 || s_if[1].dec_req_ready !== 1'b1 ||
        s_if[0].dec_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL rr_cycle1 got id=%0d rdy=%b%b want id=2 rdy=10", m_if.dec_req.id,
               s_if[1].dec_req_ready, s_if[0].dec_req_ready);
    end
    step();
    idle();
    @(negedge clk);
    total++;
    if (dut.dec_ptr_q !== 1'b0 || dut.sb_vld_q !== 8'h06 || dut.sb_src_q[2] !== 1'b1 ||
        dut.sb_src_q[1] !== 1'b0) begin
      bad++;
      $display("FAIL rr_state got ptr=%b vld=%h src1=%b src2=%b want 0 06 0 1",
               dut.dec_ptr_q, dut.sb_vld_q, dut.sb_src_q[1], dut.sb_src_q[2]);
    end
  endtask

  task automatic test_exe_rr();
    do_reset();
    s_if[0].exe_req.id = 3'd6; s_if[0].exe_req_valid = 1'b1;
    s_if[1].exe_req.id = 3'd7; s_if[1].exe_req_valid = 1'b1;
    m_if.exe_req_ready = 1'b1;
    @(negedge clk);
    total++;
    if (m_if.exe_req.id !== 3'd6 || s_if[0].exe_req_ready !== 1'b1 ||
        s_if[1].exe_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL exe_rr0 got id=%0d rdy=%b%b want id=6 rdy=01", m_if.exe_req.id,
               s_if[1].exe_req_ready, s_if[0].exe_req_ready);
    end
    step();
    @(negedge clk);
    total++;
    if (m_if.exe_req.id !== 3'd7 || s_if[1].exe_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL exe_rr1 got id=%0d rdy1=%b want id=7 rdy1=1", m_if.exe_req.id,
               s_if[1].exe_req_ready);
    end
    step();
    idle();
    @(negedge clk);
    total++;
    if (dut.exe_ptr_q !== 1'b0 || dut.dec_ptr_q !== 1'b0 || dut.sb_vld_q !== 8'h00) begin
      bad++;
      $display("FAIL exe_state got eptr=%b dptr=%b vld=%h want 0 0 00", dut.exe_ptr_q,
               dut.dec_ptr_q, dut.sb_vld_q);
    end
  endtask

  task automatic test_lock();
    do_reset();
    s_if[1].dec_req.id = 3'd3; s_if[1].dec_req.instr = 16'h5a5a;
    s_if[1].dec_req_valid = 1'b1;
    @(negedge clk);
    total++;
    if (m_if.dec_req_valid !== 1'b1 || m_if.dec_req.id !== 3'd3) begin
      bad++;
      $display("FAIL lock_c0 got v=%b id=%0d want v=1 id=3", m_if.dec_req_valid,
               m_if.dec_req.id);
    end
    step();
    s_if[0].dec_req.id = 3'd6; s_if[0].dec_req_valid = 1'b1;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (m_if.dec_req.id !== 3'd3 || m_if.dec_req.instr !== 16'h5a5a ||
          s_if[0].dec_req_ready !== 1'b0) begin
        bad++;
        $display("FAIL lock_hold c=%0d got id=%0d instr=%h rdy0=%b want 3 5a5a 0", c,
                 m_if.dec_req.id, m_if.dec_req.instr, s_if[0].dec_req_ready);
      end
      step();
    end
    m_if.dec_req_ready = 1'b1;
    @(negedge clk);
    total++;
    if (m_if.dec_req.id !== 3'd3 || s_if[1].dec_req_ready !== 1'b1 ||
        s_if[0].dec_req_ready !== 1'b0) begin
      bad++;
      $display("FAIL lock_hs got id=%0d rdy=%b%b want id=3 rdy=10", m_if.dec_req.id,
               s_if[1].dec_req_ready, s_if[0].dec_req_ready);
    end
    step();
    s_if[1].dec_req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (m_if.dec_req.id !== 3'd6 || s_if[0].dec_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL lock_next got id=%0d rdy0=%b want id=6 rdy0=1", m_if.dec_req.id,
               s_if[0].dec_req_ready);
    end
    step();
    s_if[0].dec_req_valid = 1'b0;
    m_if.dec_req_ready = 1'b0;
    @(negedge clk);
    total++;
    if (dut.sb_vld_q !== 8'h48 || dut.sb_src_q[3] !== 1'b1 || dut.sb_src_q[6] !== 1'b0) begin
      bad++;
      $display("FAIL lock_sb got vld=%h src3=%b src6=%b want 48 1 0", dut.sb_vld_q,
               dut.sb_src_q[3], dut.sb_src_q[6]);
    end
  endtask

  // Relies on the scoreboard left by test_lock: id3 -> slv1, id6 -> slv0.
  task automatic test_rsp_route();
    m_if.dec_rsp.id = 3'd3; m_if.dec_rsp.data = 16'habcd; m_if.dec_rsp_valid = 1'b1;
    s_if[0].dec_rsp_ready = 1'b0; s_if[1].dec_rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (s_if[1].dec_rsp_valid !== 1'b1 || s_if[0].dec_rsp_valid !== 1'b0 ||
        s_if[1].dec_rsp.data !== 16'habcd || s_if[0].dec_rsp !== '0 ||
        m_if.dec_rsp_ready !== 1'b1) begin
      bad++;
      $display("FAIL rsp_dec3 got v=%b%b d1=%h p0=%h mrdy=%b want v=10 d1=abcd p0=0 mrdy=1",
               s_if[1].dec_rsp_valid, s_if[0].dec_rsp_valid, s_if[1].dec_rsp.data,
               s_if[0].dec_rsp, m_if.dec_rsp_ready);
    end
    step();
    s_if[0].dec_rsp_ready = 1'b1; s_if[1].dec_rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (m_if.dec_rsp_ready !== 1'b0) begin
      bad++; $display("FAIL rsp_dec3_rdy got=%b want=0", m_if.dec_rsp_ready);
    end
    m_if.dec_rsp.id = 3'd6;
    #1;
    total++;
    if (s_if[0].dec_rsp_valid !== 1'b1 || s_if[1].dec_rsp_valid !== 1'b0 ||
        m_if.dec_rsp_ready !== 1'b1) begin
      bad++;
      $display("FAIL rsp_dec6 got v=%b%b mrdy=%b want v=01 mrdy=1", s_if[1].dec_rsp_valid,
               s_if[0].dec_rsp_valid, m_if.dec_rsp_ready);
    end
    step();
    idle();
    m_if.exe_rsp.id = 3'd3; m_if.exe_rsp.data = 16'h1234; m_if.exe_rsp_valid = 1'b1;
    s_if[1].exe_rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (s_if[1].exe_rsp_valid !== 1'b1 || s_if[0].exe_rsp_valid !== 1'b0 ||
        s_if[0].exe_rsp !== '0 || m_if.exe_rsp_ready !== 1'b1) begin
      bad++;
      $display("FAIL rsp_exe3 got v=%b%b p0=%h mrdy=%b want v=10 p0=0 mrdy=1",
               s_if[1].exe_rsp_valid, s_if[0].exe_rsp_valid, s_if[0].exe_rsp,
               m_if.exe_rsp_ready);
    end
    step();
    idle();
    @(negedge clk);
    total++;
    if (dut.sb_vld_q !== 8'h40) begin
      bad++; $display("FAIL rsp_free got vld=%h want 40", dut.sb_vld_q);
    end
  endtask

`ifndef XADAC_ARB_ID_CHECK_EN
  task automatic test_alloc_wins();
    do_reset();
    s_if[0].dec_req.id = 3'd5; s_if[0].dec_req_valid = 1'b1;
    m_if.dec_req_ready = 1'b1;
    step();
    s_if[0].dec_req_valid = 1'b0;
    s_if[1].dec_req.id = 3'd5; s_if[1].dec_req_valid = 1'b1;
    m_if.exe_rsp.id = 3'd5; m_if.exe_rsp_valid = 1'b1;
    s_if[0].exe_rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (s_if[0].exe_rsp_valid !== 1'b1 || m_if.exe_rsp_ready !== 1'b1 ||
        s_if[1].dec_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL alloc_hs got v0=%b mrdy=%b rdy1=%b want 1 1 1", s_if[0].exe_rsp_valid,
               m_if.exe_rsp_ready, s_if[1].dec_req_ready);
    end
    step();
    idle();
    @(negedge clk);
    total++;
    if (dut.sb_vld_q[5] !== 1'b1 || dut.sb_src_q[5] !== 1'b1) begin
      bad++;
      $display("FAIL alloc_wins got vld5=%b src5=%b want 1 1", dut.sb_vld_q[5],
               dut.sb_src_q[5]);
    end
  endtask
`else
  task automatic test_id_check();
    do_reset();
    s_if[0].dec_req.id = 3'd2; s_if[0].dec_req_valid = 1'b1;
    m_if.dec_req_ready = 1'b1;
    step();
    s_if[0].dec_req_valid = 1'b0;
    s_if[1].dec_req.id = 3'd2; s_if[1].dec_req_valid = 1'b1;
    @(negedge clk);
    total++;
    if (s_if[1].dec_req_ready !== 1'b0 || m_if.dec_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL idchk_hold got rdy1=%b mv=%b want 0 0", s_if[1].dec_req_ready,
               m_if.dec_req_valid);
    end
    step();
    m_if.exe_rsp.id = 3'd2; m_if.exe_rsp_valid = 1'b1; s_if[0].exe_rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (s_if[1].dec_req_ready !== 1'b0 || s_if[0].exe_rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL idchk_free got rdy1=%b v0=%b want 0 1", s_if[1].dec_req_ready,
               s_if[0].exe_rsp_valid);
    end
    step();
    m_if.exe_rsp_valid = 1'b0; s_if[0].exe_rsp_ready = 1'b0;
    @(negedge clk);
    total++;
    if (s_if[1].dec_req_ready !== 1'b1 || m_if.dec_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL idchk_grant got rdy1=%b mv=%b want 1 1", s_if[1].dec_req_ready,
               m_if.dec_req_valid);
    end
    step();
    idle();
    m_if.dec_rsp.id = 3'd7; m_if.dec_rsp_valid = 1'b1;
    @(negedge clk);
    total++;
    if (m_if.dec_rsp_ready !== 1'b1 || s_if[0].dec_rsp_valid !== 1'b0 ||
        s_if[1].dec_rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL idchk_drop got mrdy=%b v=%b%b want 1 00", m_if.dec_rsp_ready,
               s_if[1].dec_rsp_valid, s_if[0].dec_rsp_valid);
    end
    step();
    idle();
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    s_if[0].dec_req.id = 3'd1; s_if[0].dec_req_valid = 1'b1;
    s_if[1].dec_req.id = 3'd2; s_if[1].dec_req_valid = 1'b1;
    m_if.dec_req_ready = 1'b1;
    step();
    step();
    s_if[0].dec_req.id = 3'd4;
    s_if[1].dec_req_valid = 1'b0;
    s_if[1].exe_req_valid = 1'b1; m_if.exe_req_ready = 1'b1;
    m_if.dec_rsp.id = 3'd1; m_if.dec_rsp_valid = 1'b1; s_if[0].dec_rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (dut.sb_vld_q !== 8'h06 || s_if[0].dec_rsp_valid !== 1'b1 ||
        m_if.dec_req_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got vld=%h v0=%b mv=%b want 06 1 1", dut.sb_vld_q,
               s_if[0].dec_rsp_valid, m_if.dec_req_valid);
    end
    #1 rstn = 1'b0;
    #1;
    total++;
    if (m_if.dec_req_valid !== 1'b0 || m_if.exe_req_valid !== 1'b0 ||
        s_if[0].dec_req_ready !== 1'b0 || s_if[1].exe_req_ready !== 1'b0 ||
        s_if[0].dec_rsp_valid !== 1'b0 || m_if.dec_rsp_ready !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async got mv=%b%b srdy=%b%b sv=%b mrdy=%b want all 0",
               m_if.dec_req_valid, m_if.exe_req_valid, s_if[0].dec_req_ready,
               s_if[1].exe_req_ready, s_if[0].dec_rsp_valid, m_if.dec_rsp_ready);
    end
    idle();
    step();
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (dut.sb_vld_q !== 8'h00 || dut.dec_ptr_q !== 1'b0 || dut.exe_ptr_q !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_post got vld=%h ptr=%b/%b want 00 0/0", dut.sb_vld_q,
               dut.dec_ptr_q, dut.exe_ptr_q);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    idle();
    test_reset();
    test_dec_rr();
    test_exe_rr();
    test_lock();
    test_rsp_route();
`ifndef XADAC_ARB_ID_CHECK_EN
    test_alloc_wins();
`else
    test_id_check();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
